// File: rtl/combo_pkg.sv
// Shared types and constants for the combo/score sequencer: note grades,
// base score per grade, combo tier thresholds and the controller states.
package combo_pkg;

    typedef enum logic [1:0] {
        MISS    = 2'd0,
        GOOD    = 2'd1,
        GREAT   = 2'd2,
        PERFECT = 2'd3
    } grade_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Points awarded per accepted note before the combo multiplier.
    localparam logic [2:0] BASE_MISS    = 3'd0;
    localparam logic [2:0] BASE_GOOD    = 3'd1;
    localparam logic [2:0] BASE_GREAT   = 3'd2;
    localparam logic [2:0] BASE_PERFECT = 3'd4;

    // Highest combo value that still belongs to tier x1..x4; above x4 is x5.
    localparam int unsigned TIER_X1_MAX = 5;
    localparam int unsigned TIER_X2_MAX = 13;
    localparam int unsigned TIER_X3_MAX = 24;
    localparam int unsigned TIER_X4_MAX = 38;

    function automatic logic [2:0] base_of(input logic [1:0] grade);
        case (grade)
            GOOD:    base_of = BASE_GOOD;
            GREAT:   base_of = BASE_GREAT;
            PERFECT: base_of = BASE_PERFECT;
            default: base_of = BASE_MISS;
        endcase
    endfunction

endpackage

// File: rtl/combo_tier.sv
// Combinational combo-count to score-multiplier (x1..x5) mapping.
module combo_tier
    import combo_pkg::*;
#(
    parameter int COMBO_W = 8
) (
    input  logic [COMBO_W-1:0] combo,
    output logic [2:0]         mult
);

    logic [31:0] combo_ext;

    // Walk the tier thresholds from the lowest tier upward.
    always_comb begin
        combo_ext = 32'(combo);
        if (combo_ext <= TIER_X1_MAX) begin
            mult = 3'd1;
        end else if (combo_ext <= TIER_X2_MAX) begin
            mult = 3'd2;
        end else if (combo_ext <= TIER_X3_MAX) begin
            mult = 3'd3;
        end else if (combo_ext <= TIER_X4_MAX) begin
            mult = 3'd4;
        end else begin
            mult = 3'd5;
        end
    end

endmodule

// File: rtl/combo_score_ctrl.sv
// Per-song scoring sequencer: accepts judged notes, keeps the combo and its
// multiplier tier, and adds base x multiplier to the score one add per cycle.
// Optional build macro COMBO_MAX_TRACK_EN enables the longest-combo register;
// without it max_combo reads as zero.
module combo_score_ctrl
    import combo_pkg::*;
#(
    parameter int SCORE_W = 20,
    parameter int COMBO_W = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               game_start,
    input  logic               game_end,
    input  logic               hit_valid,
    input  logic [1:0]         hit_grade,
    output logic               hit_ready,
    output logic [COMBO_W-1:0] combo_count,
    output logic [2:0]         multiplier,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid,
    output logic [1:0]         state,
    output logic [COMBO_W-1:0] max_combo
);

    state_t             state_q, state_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [2:0]         mult_q, tier_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         base_q, base_d;
    logic [2:0]         adds_left_q, adds_left_d;
    logic               end_pending_q, end_pending_d, end_seen;
    logic               valid_q, valid_d;
    logic               accept, is_miss;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                   input logic [2:0]         inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, acc} + (SCORE_W+1)'(inc);
        if (sum[SCORE_W]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] cnt);
        if (&cnt) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + COMBO_W'(1);
        end
    endfunction

    assign hit_ready = (state_q == ACTIVE) && !game_start && !game_end;
    assign accept    = hit_valid && hit_ready;
    assign is_miss   = (hit_grade == MISS);

    // Next combo: game_start wipes it, a miss breaks it, any other hit extends it.
    always_comb begin
        combo_d = combo_q;
        if (game_start) begin
            combo_d = '0;
        end else if (accept) begin
            combo_d = is_miss ? '0 : sat_inc(combo_q);
        end
    end

    // Tier is taken from the post-update combo so the hit that crosses a
    // threshold is already scored at the new multiplier.
    combo_tier #(.COMBO_W(COMBO_W)) u_tier (
        .combo (combo_d),
        .mult  (tier_d)
    );

    // Next-state and datapath updates; game_start overrides everything else.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        base_d        = base_q;
        adds_left_d   = adds_left_q;
        end_pending_d = end_pending_q;
        end_seen      = 1'b0;
        valid_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (game_start) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (game_start) begin
                    state_d = ACTIVE;
                end else if (game_end) begin
                    state_d = DONE;
                end else if (accept) begin
                    if (is_miss) begin
                        valid_d = 1'b1;
                    end else begin
                        base_d      = base_of(hit_grade);
                        adds_left_d = tier_d;
                        state_d     = ADD;
                    end
                end
            end
            ADD: begin
                if (game_start) begin
                    state_d = ACTIVE;
                end else begin
                    score_d       = sat_add(score_q, base_q);
                    adds_left_d   = adds_left_q - 3'd1;
                    end_seen      = end_pending_q | game_end;
                    end_pending_d = end_seen;
                    if (adds_left_q == 3'd1) begin
                        valid_d       = 1'b1;
                        end_pending_d = 1'b0;
                        state_d       = end_seen ? DONE : ACTIVE;
                    end
                end
            end
            default: begin
                if (game_start) begin
                    state_d = ACTIVE;
                end
            end
        endcase
        if (game_start) begin
            score_d       = '0;
            base_d        = '0;
            adds_left_d   = '0;
            end_pending_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            combo_q       <= '0;
            mult_q        <= 3'd1;
            score_q       <= '0;
            base_q        <= '0;
            adds_left_q   <= '0;
            end_pending_q <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            combo_q       <= combo_d;
            mult_q        <= tier_d;
            score_q       <= score_d;
            base_q        <= base_d;
            adds_left_q   <= adds_left_d;
            end_pending_q <= end_pending_d;
            valid_q       <= valid_d;
        end
    end

`ifdef COMBO_MAX_TRACK_EN
    logic [COMBO_W-1:0] max_q;

    // Longest combo this song, compared against the post-update combo.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            max_q <= '0;
        end else if (game_start) begin
            max_q <= '0;
        end else if (combo_d > max_q) begin
            max_q <= combo_d;
        end
    end

    assign max_combo = max_q;
`else
    assign max_combo = '0;
`endif

    assign combo_count = combo_q;
    assign multiplier  = mult_q;
    assign score       = score_q;
    assign score_valid = valid_q;
    assign state       = state_q;

endmodule

// File: tb/tb_combo_score_ctrl.sv
// Self-checking bench for combo_score_ctrl: directed scenarios plus random
// grade streams checked against a transaction-level scoring model.
module tb_combo_score_ctrl;

    localparam int SMAX  = (1 << 20) - 1;
    localparam int S4MAX = 15;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        game_start = 1'b0;
    logic        game_end = 1'b0;
    logic        hit_valid = 1'b0;
    logic [1:0]  hit_grade = 2'd0;
    logic        hit_ready;
    logic [7:0]  combo_count;
    logic [2:0]  multiplier;
    logic [19:0] score;
    logic        score_valid;
    logic [1:0]  state;
    logic [7:0]  max_combo;

    logic        gs4 = 1'b0;
    logic        ge4 = 1'b0;
    logic        hv4 = 1'b0;
    logic [1:0]  hg4 = 2'd3;
    logic        hr4;
    logic [7:0]  cc4;
    logic [2:0]  mu4;
    logic [3:0]  sc4;
    logic        sv4;
    logic [1:0]  st4;
    logic [7:0]  mx4;

    int n_chk  = 0;
    int n_fail = 0;

    int m_score = 0;
    int m_combo = 0;
    int m_max   = 0;

    always #5 Clk = ~Clk;

    combo_score_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .game_start  (game_start),
        .game_end    (game_end),
        .hit_valid   (hit_valid),
        .hit_grade   (hit_grade),
        .hit_ready   (hit_ready),
        .combo_count (combo_count),
        .multiplier  (multiplier),
        .score       (score),
        .score_valid (score_valid),
        .state       (state),
        .max_combo   (max_combo)
    );

    combo_score_ctrl #(.SCORE_W(4), .COMBO_W(8)) dut4 (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .game_start  (gs4),
        .game_end    (ge4),
        .hit_valid   (hv4),
        .hit_grade   (hg4),
        .hit_ready   (hr4),
        .combo_count (cc4),
        .multiplier  (mu4),
        .score       (sc4),
        .score_valid (sv4),
        .state       (st4),
        .max_combo   (mx4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tier_of(input int c);
        if (c <= 5)  return 1;
        if (c <= 13) return 2;
        if (c <= 24) return 3;
        if (c <= 38) return 4;
        return 5;
    endfunction

    function automatic int exp_max();
`ifdef COMBO_MAX_TRACK_EN
        return m_max;
`else
        return 0;
`endif
    endfunction

    // Apply one accepted note to the model; returns cycles from accept to score_valid.
    task automatic model_hit(input logic [1:0] g, output int exp_lat);
        int b;
        int m;
        b = (g == 2'd0) ? 0 : (g == 2'd1) ? 1 : (g == 2'd2) ? 2 : 4;
        if (g == 2'd0) begin
            m_combo = 0;
            exp_lat = 1;
        end else begin
            m_combo = (m_combo < 255) ? m_combo + 1 : 255;
            m = tier_of(m_combo);
            m_score = m_score + b * m;
            if (m_score > SMAX) m_score = SMAX;
            exp_lat = m + 1;
        end
        if (m_combo > m_max) m_max = m_combo;
    endtask

    task automatic model_clear();
        m_score = 0;
        m_combo = 0;
        m_max   = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_score"}, 32'(score), 32'(m_score));
        check({tag, "_combo"}, 32'(combo_count), 32'(m_combo));
        check({tag, "_mult"}, 32'(multiplier), 32'(tier_of(m_combo)));
        check({tag, "_max"}, 32'(max_combo), 32'(exp_max()));
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        model_clear();
    endtask

    // Issue one note on hit_ready, then wait for its score_valid and check it.
    task automatic send(input logic [1:0] g);
        int n;
        int lat;
        int exp_lat;
        n = 0;
        while (hit_ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("ready_wait", 32'(n < 50), 32'd1);
        hit_valid = 1'b1;
        hit_grade = g;
        @(negedge Clk);
        hit_valid = 1'b0;
        model_hit(g, exp_lat);
        lat = 1;
        while (score_valid !== 1'b1 && lat < 12) begin
            @(negedge Clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("state_after", 32'(state), 32'd1);
        check_model("hit");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t6[6];
        int lat;
        int el;
        int e4;
        int n;
        t6 = '{4, 8, 12, 16, 20, 28};

        // Reset state
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_combo", 32'(combo_count), 32'd0);
        check("rst_mult", 32'(multiplier), 32'd1);
        check("rst_valid", 32'(score_valid), 32'd0);
        check("rst_max", 32'(max_combo), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        hit_valid = 1'b1;
        #1 check("idle_ready", 32'(hit_ready), 32'd0);
        hit_valid = 1'b0;
        game_end = 1'b1;
        @(negedge Clk);
        game_end = 1'b0;
        check("idle_end_ignored", 32'(state), 32'd0);

        // Six back-to-back PERFECTs
        pulse_start();
        check("start_state", 32'(state), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send(2'd3);
            check("p6_score", 32'(score), 32'(t6[i]));
        end
        check("p6_combo", 32'(combo_count), 32'd6);
        check("p6_mult", 32'(multiplier), 32'd2);

        // 39 GOODs then a MISS
        pulse_start();
        for (int i = 0; i < 39; i++) send(2'd1);
        check("g39_score", 32'(score), 32'd115);
        check("g39_mult", 32'(multiplier), 32'd5);
        send(2'd0);
        check("miss_score", 32'(score), 32'd115);
        check("miss_combo", 32'(combo_count), 32'd0);
        check("miss_mult", 32'(multiplier), 32'd1);

        // Longest combo: 10 hits, miss, 3 hits
        pulse_start();
        for (int i = 0; i < 10; i++) send(2'd2);
        send(2'd0);
        for (int i = 0; i < 3; i++) send(2'd1);
`ifdef COMBO_MAX_TRACK_EN
        check("max_after", 32'(max_combo), 32'd10);
`else
        check("max_after", 32'(max_combo), 32'd0);
`endif
        pulse_start();
        check("max_cleared", 32'(max_combo), 32'd0);

        // game_end during the 2nd cycle of a 5-cycle ADD
        for (int i = 0; i < 38; i++) send(2'd1);
        hit_valid = 1'b1;
        hit_grade = 2'd1;
        @(negedge Clk);
        hit_valid = 1'b0;
        model_hit(2'd1, el);
        @(negedge Clk);
        game_end = 1'b1;
        @(negedge Clk);
        game_end = 1'b0;
        lat = 3;
        while (score_valid !== 1'b1 && lat < 12) begin
            @(negedge Clk);
            lat++;
        end
        check("end_latency", 32'(lat), 32'(el));
        check("end_score", 32'(score), 32'(m_score));
        check("end_state", 32'(state), 32'd3);
        hit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            #1 check("done_ready", 32'(hit_ready), 32'd0);
        end
        hit_valid = 1'b0;
        check("done_score", 32'(score), 32'(m_score));
        check("done_state", 32'(state), 32'd3);
        check("done_valid", 32'(score_valid), 32'd0);

        // game_start together with a hit in ACTIVE
        pulse_start();
        for (int i = 0; i < 3; i++) send(2'd1);
        game_start = 1'b1;
        hit_valid = 1'b1;
        hit_grade = 2'd3;
        #1 check("gs_hit_ready", 32'(hit_ready), 32'd0);
        @(negedge Clk);
        game_start = 1'b0;
        hit_valid = 1'b0;
        model_clear();
        check("gs_hit_state", 32'(state), 32'd1);
        check_model("gs_hit");

        // game_start mid-ADD aborts without score_valid
        send(2'd2);
        send(2'd2);
        hit_valid = 1'b1;
        hit_grade = 2'd3;
        @(negedge Clk);
        hit_valid = 1'b0;
        check("abort_in_add", 32'(state), 32'd2);
        game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        model_clear();
        check("abort_state", 32'(state), 32'd1);
        check("abort_valid", 32'(score_valid), 32'd0);
        check_model("abort");
        @(negedge Clk);
        check("abort_valid2", 32'(score_valid), 32'd0);

        // Random grade stream
        for (int i = 0; i < 80; i++) send(2'($urandom_range(0, 3)));

        // Long non-miss stream drives combo to saturation
        pulse_start();
        for (int i = 0; i < 260; i++) send(2'($urandom_range(1, 3)));
        check("combo_sat", 32'(combo_count), 32'd255);

        // Asynchronous reset in the middle of an ADD
        hit_valid = 1'b1;
        hit_grade = 2'd3;
        @(negedge Clk);
        hit_valid = 1'b0;
        @(negedge Clk);
        check("pre_rst_add", 32'(state), 32'd2);
        #1 Reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_score", 32'(score), 32'd0);
        check("arst_combo", 32'(combo_count), 32'd0);
        check("arst_mult", 32'(multiplier), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_clear();
        @(negedge Clk);
        check("arst_idle", 32'(state), 32'd0);

        // Narrow score accumulator saturates at 15
        gs4 = 1'b1;
        @(negedge Clk);
        gs4 = 1'b0;
        e4 = 0;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (hr4 !== 1'b1 && n < 20) begin
                @(negedge Clk);
                n++;
            end
            hv4 = 1'b1;
            @(negedge Clk);
            hv4 = 1'b0;
            n = 0;
            while (sv4 !== 1'b1 && n < 12) begin
                @(negedge Clk);
                n++;
            end
            e4 = (e4 + 4 > S4MAX) ? S4MAX : e4 + 4;
            check("sat4_score", 32'(sc4), 32'(e4));
        end
        check("sat4_mult", 32'(mu4), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
